// File: rtl/adat_frame_writer_if.sv
// Bundles the ADAT bit-stream input, the channel-buffer write port and the
// frame status outputs of adat_frame_writer into one interface.
interface adat_frame_writer_if #(
  parameter int FRAME_BITS = 3
);
  // Decoded ADAT stream from the line receiver
  logic                    bit_i;
  logic                    bit_valid_i;
  logic                    frame_start_i;
  // Channel buffer write port
  logic                    write_data_o;
  logic [FRAME_BITS+7:0]   write_addr_o;
  logic                    wr_en_o;
  // Frame status towards the downstream reader
  logic [3:0]              user_bits_o;
  logic [FRAME_BITS-1:0]   frame_idx_o;
  logic                    frame_done_o;
  logic                    error_o;

  // Frame writer side
  modport master (
    input  bit_i, bit_valid_i, frame_start_i,
    output write_data_o, write_addr_o, wr_en_o,
    output user_bits_o, frame_idx_o, frame_done_o, error_o
  );

  // Environment side (receiver, buffer and reader)
  modport slave (
    output bit_i, bit_valid_i, frame_start_i,
    input  write_data_o, write_addr_o, wr_en_o,
    input  user_bits_o, frame_idx_o, frame_done_o, error_o
  );
endinterface

// File: rtl/adat_frame_writer.sv
// ADAT frame writer: strips separator bits from the decoded ADAT stream,
// writes the 8x24 audio bits of each frame into a circular bit buffer at
// {slot, channel, bit}, captures the user nibble and publishes the slot of
// the last complete frame. Malformed or truncated frames raise error_o.
module adat_frame_writer #(
  parameter int FRAME_BITS = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  adat_frame_writer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    USER = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                  state;
  logic [1:0]              user_cnt;   // user bits received so far
  logic [3:0]              user_sh;    // user nibble being captured, MSB first
  logic [2:0]              nib_pos;    // 0 = separator, 1..4 = data bits
  logic [4:0]              bit_n;      // data bit within sample, 0 = MSB
  logic [2:0]              chan;       // channel being received
  logic [FRAME_BITS-1:0]   slot;       // buffer slot being written
  logic                    done_pend;  // final write issued, publish next cycle

  logic                    write_data_r;
  logic [FRAME_BITS+7:0]   write_addr_r;
  logic                    wr_en_r;
  logic [3:0]              user_bits_r;
  logic [FRAME_BITS-1:0]   frame_idx_r;
  logic                    frame_done_r;
  logic                    error_r;

  assign bus.write_data_o = write_data_r;
  assign bus.write_addr_o = write_addr_r;
  assign bus.wr_en_o      = wr_en_r;
  assign bus.user_bits_o  = user_bits_r;
  assign bus.frame_idx_o  = frame_idx_r;
  assign bus.frame_done_o = frame_done_r;
  assign bus.error_o      = error_r;

  // Frame parser FSM with registered buffer writes and status pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      user_cnt     <= 2'd0;
      user_sh      <= 4'd0;
      nib_pos      <= 3'd0;
      bit_n        <= 5'd0;
      chan         <= 3'd0;
      slot         <= {FRAME_BITS{1'b0}};
      done_pend    <= 1'b0;
      write_data_r <= 1'b0;
      write_addr_r <= {(FRAME_BITS+8){1'b0}};
      wr_en_r      <= 1'b0;
      user_bits_r  <= 4'd0;
      frame_idx_r  <= {FRAME_BITS{1'b1}};
      frame_done_r <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below
      wr_en_r      <= 1'b0;
      error_r      <= 1'b0;
      frame_done_r <= 1'b0;

      // Publish the completed frame one cycle after its final write
      if (done_pend) begin
        done_pend    <= 1'b0;
        frame_done_r <= 1'b1;
        frame_idx_r  <= slot;
        user_bits_r  <= user_sh;
        slot         <= slot + FRAME_BITS'(1);
      end

      if (bus.bit_valid_i) begin
        if (bus.frame_start_i) begin
          // A sync while a frame is in flight aborts it; the new frame
          // restarts in the same slot because slot only moves on completion.
          if (state != IDLE) begin
            error_r <= 1'b1;
          end
          state    <= USER;
          user_cnt <= 2'd0;
          nib_pos  <= 3'd0;
          bit_n    <= 5'd0;
          chan     <= 3'd0;
        end else begin
          case (state)
            IDLE: begin
              state <= IDLE;
            end
            USER: begin
              user_sh  <= {user_sh[2:0], bus.bit_i};
              user_cnt <= user_cnt + 2'd1;
              if (user_cnt == 2'd3) begin
                state   <= DATA;
                nib_pos <= 3'd0;
              end
            end
            DATA: begin
              if (nib_pos == 3'd0) begin
                // Separator must be '1'; a '0' means we lost framing
                if (!bus.bit_i) begin
                  error_r <= 1'b1;
                  state   <= IDLE;
                end else begin
                  nib_pos <= 3'd1;
                end
              end else begin
                wr_en_r      <= 1'b1;
                write_data_r <= bus.bit_i;
                write_addr_r <= {slot, chan, 5'd23 - bit_n};
                nib_pos      <= (nib_pos == 3'd4) ? 3'd0 : nib_pos + 3'd1;
                if (bit_n == 5'd23) begin
                  bit_n <= 5'd0;
                  if (chan == 3'd7) begin
                    chan      <= 3'd0;
                    state     <= IDLE;
                    done_pend <= 1'b1;
                  end else begin
                    chan <= chan + 3'd1;
                  end
                end else begin
                  bit_n <= bit_n + 5'd1;
                end
              end
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
